// File: rtl/lfsr_8_seq_checker_if.sv
// Stream and status bundle between an LFSR pattern source and the sequence checker.
// data_i bit 7 carries LFSR state bit 1 (the MSB).
interface lfsr_8_seq_checker_if #(
  parameter int unsigned ERR_W = 16
);
  logic [7:0]       data_i;
  logic             valid_i;
  logic             clear_err_i;
  logic             locked_o;
  logic             word_err_o;
  logic             zero_detect_o;
  logic [ERR_W-1:0] err_count_o;
  logic [7:0]       expected_o;

  modport master (
    output data_i, valid_i, clear_err_i,
    input  locked_o, word_err_o, zero_detect_o, err_count_o, expected_o
  );

  modport slave (
    input  data_i, valid_i, clear_err_i,
    output locked_o, word_err_o, zero_detect_o, err_count_o, expected_o
  );
endinterface

// File: rtl/lfsr_8_seq_checker.sv
// Receive-side checker for the 8-bit Galois LFSR stream: seeds from data, verifies,
// then flywheels on its own prediction while counting mismatching words.
module lfsr_8_seq_checker #(
  parameter logic [7:0]  TAP_COEFF    = 8'b1100_1111,
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned UNLOCK_COUNT = 3,
  parameter int unsigned ERR_W        = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  lfsr_8_seq_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_e;

  localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);

  // Vector bit i holds LFSR bit 8-i, so tap T[9-k] lands on TAP_COEFF[7-i].
  function automatic logic [7:0] lfsr_nxt(input logic [7:0] s);
    logic [7:0] n;
    n[7] = s[0];
    for (int i = 0; i < 7; i++) begin
      n[i] = s[i+1] ^ (TAP_COEFF[7-i] & s[0]);
    end
    return n;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + {{(ERR_W-1){1'b0}}, 1'b1};
  endfunction

  state_e           state_q;
  logic [7:0]       exp_q;
  logic [3:0]       match_q;
  logic [3:0]       miss_q;
  logic             locked_q;
  logic             word_err_q;
  logic             zero_q;
  logic [ERR_W-1:0] err_q;

  logic       is_zero_d;
  logic       hit_d;
  logic [7:0] seed_d;
  logic [7:0] fly_d;
  logic       err_inc_d;

  assign is_zero_d = (bus.data_i == 8'h00);
  assign hit_d     = (bus.data_i == exp_q);
  assign seed_d    = lfsr_nxt(bus.data_i);
  assign fly_d     = lfsr_nxt(exp_q);
  assign err_inc_d = bus.valid_i && (state_q == LOCK) && !hit_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      exp_q      <= 8'h00;
      match_q    <= 4'd0;
      miss_q     <= 4'd0;
      locked_q   <= 1'b0;
      word_err_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      word_err_q <= 1'b0;
      zero_q     <= 1'b0;
      if (bus.valid_i) begin
        zero_q <= is_zero_d;
        unique case (state_q)
          HUNT: begin
            if (!is_zero_d) begin
              exp_q   <= seed_d;
              match_q <= 4'd0;
              state_q <= VERIFY;
            end
          end
          VERIFY: begin
            if (is_zero_d) begin
              match_q <= 4'd0;
              state_q <= HUNT;
            end else if (hit_d) begin
              exp_q <= seed_d;
              if (match_q + 4'd1 == LOCK_N) begin
                match_q  <= 4'd0;
                miss_q   <= 4'd0;
                locked_q <= 1'b1;
                state_q  <= LOCK;
              end else begin
                match_q <= match_q + 4'd1;
              end
            end else begin
              exp_q   <= seed_d;
              match_q <= 4'd0;
            end
          end
          LOCK: begin
            // Once locked the prediction never follows the data, so corrupt words cannot reseed it.
            exp_q <= fly_d;
            if (hit_d) begin
              miss_q <= 4'd0;
            end else begin
              word_err_q <= 1'b1;
              if (miss_q + 4'd1 == UNLOCK_N) begin
                miss_q   <= 4'd0;
                locked_q <= 1'b0;
                state_q  <= HUNT;
              end else begin
                miss_q <= miss_q + 4'd1;
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  // Clear takes priority over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (bus.clear_err_i) begin
      err_q <= '0;
    end else if (err_inc_d) begin
      err_q <= sat_inc(err_q);
    end
  end

  assign bus.locked_o      = locked_q;
  assign bus.word_err_o    = word_err_q;
  assign bus.zero_detect_o = zero_q;
  assign bus.err_count_o   = err_q;
  assign bus.expected_o    = exp_q;

endmodule

// File: tb/tb_lfsr_8_seq_checker.sv
// Directed bench for lfsr_8_seq_checker: table of stream vectors plus hand-written
// sequences for saturation, Data_Valid gaps and asynchronous reset.
module tb_lfsr_8_seq_checker;

  localparam logic [1:8] TAPS = 8'b1100_1111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d_r = 8'h00;
  logic       v_r = 1'b0;
  logic       c_r = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] seq [0:255];

  lfsr_8_seq_checker_if #(.ERR_W(16)) bus16 ();
  lfsr_8_seq_checker_if #(.ERR_W(4))  bus4 ();

  assign bus16.data_i      = d_r;
  assign bus16.valid_i     = v_r;
  assign bus16.clear_err_i = c_r;
  assign bus4.data_i       = d_r;
  assign bus4.valid_i      = v_r;
  assign bus4.clear_err_i  = c_r;

  lfsr_8_seq_checker #(.ERR_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus16));
  lfsr_8_seq_checker #(.ERR_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  always #5 clk = ~clk;

  function automatic logic [1:8] m_nxt(input logic [1:8] s);
    logic [1:8] n;
    n[1] = s[8];
    for (int k = 2; k <= 8; k++) n[k] = s[k-1] ^ (TAPS[9-k] & s[8]);
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic apply(input logic vld, input logic [7:0] dat, input logic clr);
    @(negedge clk);
    v_r = vld;
    d_r = dat;
    c_r = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    v_r = 1'b0;
    c_r = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic vld;
    int   idx;   // -1: zero word, -2: don't-care gap data
    logic clr;
    logic [7:0] xm;
    logic lk;
    logic we;
    logic zd;
    int   err;
    int   eidx;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic vld, int idx, logic [7:0] xm, logic clr,
                              logic lk, logic we, logic zd, int err, int eidx);
    vec_t r;
    r.vld = vld; r.idx = idx; r.xm = xm; r.clr = clr;
    r.lk = lk; r.we = we; r.zd = zd; r.err = err; r.eidx = eidx;
    return r;
  endfunction

  initial begin
    int p;
    int nerr;
    logic [7:0] dat;

    seq[0] = 8'h91;
    for (int i = 1; i < 256; i++) seq[i] = m_nxt(seq[i-1]);

    //            vld idx  xm     clr lk we zd err eidx
    tbl.push_back(mk(1,  0, 8'h00, 0, 0, 0, 0, 0,  1));
    tbl.push_back(mk(1,  1, 8'h00, 0, 0, 0, 0, 0,  2));
    tbl.push_back(mk(1,  2, 8'h00, 0, 0, 0, 0, 0,  3));
    tbl.push_back(mk(1,  3, 8'h00, 0, 0, 0, 0, 0,  4));
    tbl.push_back(mk(1,  4, 8'h00, 0, 1, 0, 0, 0,  5));
    tbl.push_back(mk(0, -2, 8'h00, 0, 1, 0, 0, 0,  5));
    tbl.push_back(mk(1,  5, 8'h00, 0, 1, 0, 0, 0,  6));
    tbl.push_back(mk(1,  6, 8'h01, 0, 1, 1, 0, 1,  7));
    tbl.push_back(mk(1,  7, 8'h00, 0, 1, 0, 0, 1,  8));
    tbl.push_back(mk(1,  8, 8'h00, 0, 1, 0, 0, 1,  9));
    tbl.push_back(mk(0, -2, 8'h00, 0, 1, 0, 0, 1,  9));
    tbl.push_back(mk(1,  9, 8'h01, 0, 1, 1, 0, 2, 10));
    tbl.push_back(mk(1, 10, 8'h01, 0, 1, 1, 0, 3, 11));
    tbl.push_back(mk(1, 11, 8'h01, 0, 0, 1, 0, 4, 12));
    tbl.push_back(mk(1, 12, 8'h00, 0, 0, 0, 0, 4, 13));
    tbl.push_back(mk(1, 13, 8'h00, 0, 0, 0, 0, 4, 14));
    tbl.push_back(mk(1, 14, 8'h00, 0, 0, 0, 0, 4, 15));
    tbl.push_back(mk(1, 15, 8'h00, 0, 0, 0, 0, 4, 16));
    tbl.push_back(mk(1, 16, 8'h00, 0, 1, 0, 0, 4, 17));
    tbl.push_back(mk(1, -1, 8'h00, 0, 1, 1, 1, 5, 18));
    tbl.push_back(mk(1, 18, 8'h00, 0, 1, 0, 0, 5, 19));
    tbl.push_back(mk(1, 19, 8'h01, 0, 1, 1, 0, 6, 20));
    tbl.push_back(mk(1, 20, 8'h01, 0, 1, 1, 0, 7, 21));
    tbl.push_back(mk(1, 21, 8'h01, 0, 0, 1, 0, 8, 22));
    tbl.push_back(mk(1, -1, 8'h00, 0, 0, 0, 1, 8, 22));
    tbl.push_back(mk(1, 22, 8'h00, 0, 0, 0, 0, 8, 23));
    tbl.push_back(mk(1, 23, 8'h00, 0, 0, 0, 0, 8, 24));
    tbl.push_back(mk(1, -1, 8'h00, 0, 0, 0, 1, 8, 24));
    tbl.push_back(mk(1, 24, 8'h00, 0, 0, 0, 0, 8, 25));
    tbl.push_back(mk(1, 25, 8'h00, 0, 0, 0, 0, 8, 26));
    tbl.push_back(mk(1, 26, 8'h00, 0, 0, 0, 0, 8, 27));
    tbl.push_back(mk(1, 27, 8'h00, 0, 0, 0, 0, 8, 28));
    tbl.push_back(mk(1, 28, 8'h00, 0, 1, 0, 0, 8, 29));
    tbl.push_back(mk(1, 29, 8'h01, 1, 1, 1, 0, 0, 30));
    tbl.push_back(mk(1, 30, 8'h00, 0, 1, 0, 0, 0, 31));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked",   32'(bus16.locked_o), 32'd0);
    chk("rst_word_err", 32'(bus16.word_err_o), 32'd0);
    chk("rst_zero",     32'(bus16.zero_detect_o), 32'd0);
    chk("rst_err",      32'(bus16.err_count_o), 32'd0);
    chk("rst_expected", 32'(bus16.expected_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Seed examples and reseed in VERIFY
    apply(1, 8'h91, 0);
    chk("seed_91", 32'(bus16.expected_o), 32'hBB);
    apply(1, 8'hBB, 0);
    chk("seed_bb", 32'(bus16.expected_o), 32'hAE);
    apply(1, 8'h55, 0);
    chk("reseed_exp", 32'(bus16.expected_o), 32'(m_nxt(8'h55)));
    chk("reseed_werr", 32'(bus16.word_err_o), 32'd0);
    chk("reseed_err", 32'(bus16.err_count_o), 32'd0);

    // Table-driven stream
    do_reset();
    foreach (tbl[i]) begin
      if (tbl[i].idx == -1)      dat = 8'h00;
      else if (tbl[i].idx == -2) dat = 8'hA5;
      else                       dat = seq[tbl[i].idx] ^ tbl[i].xm;
      apply(tbl[i].vld, dat, tbl[i].clr);
      chk($sformatf("v%0d_locked", i), 32'(bus16.locked_o), 32'(tbl[i].lk));
      chk($sformatf("v%0d_word_err", i), 32'(bus16.word_err_o), 32'(tbl[i].we));
      chk($sformatf("v%0d_zero", i), 32'(bus16.zero_detect_o), 32'(tbl[i].zd));
      chk($sformatf("v%0d_err", i), 32'(bus16.err_count_o), 32'(tbl[i].err));
      chk($sformatf("v%0d_expected", i), 32'(bus16.expected_o), 32'(seq[tbl[i].eidx]));
    end
    apply(0, 8'h00, 0);

    // Saturation: 20 errors with relocks between bursts
    do_reset();
    p = 0;
    for (int i = 0; i < 5; i++) begin apply(1, seq[p], 0); p++; end
    chk("sat_lock0", 32'(bus16.locked_o), 32'd1);
    nerr = 0;
    while (nerr < 20) begin
      for (int e = 0; e < 3 && nerr < 20; e++) begin
        apply(1, seq[p] ^ 8'h01, 0);
        p++;
        nerr++;
        chk("sat_word_err", 32'(bus16.word_err_o), 32'd1);
      end
      if (nerr < 20) begin
        for (int i = 0; i < 5; i++) begin apply(1, seq[p], 0); p++; end
        chk("sat_relock", 32'(bus16.locked_o), 32'd1);
      end
    end
    chk("sat_err4", 32'(bus4.err_count_o), 32'd15);
    chk("sat_err16", 32'(bus16.err_count_o), 32'd20);
    apply(1, seq[p] ^ 8'h01, 1);
    p++;
    chk("clr_err4", 32'(bus4.err_count_o), 32'd0);
    chk("clr_err16", 32'(bus16.err_count_o), 32'd0);
    chk("clr_word_err", 32'(bus16.word_err_o), 32'd1);
    apply(0, 8'h00, 0);

    // Random Data_Valid gaps while locked
    do_reset();
    p = 40;
    for (int i = 0; i < 5; i++) begin apply(1, seq[p], 0); p++; end
    for (int w = 0; w < 20; w++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        apply(0, 8'($urandom), 0);
        chk("gap_idle_werr", 32'(bus16.word_err_o), 32'd0);
      end
      apply(1, seq[p], 0);
      p++;
      chk("gap_werr", 32'(bus16.word_err_o), 32'd0);
      chk("gap_locked", 32'(bus16.locked_o), 32'd1);
      chk("gap_expected", 32'(bus16.expected_o), 32'(seq[p]));
    end
    chk("gap_err", 32'(bus16.err_count_o), 32'd0);

    // Asynchronous reset mid-lock, between clock edges
    apply(1, seq[p] ^ 8'h01, 0);
    p++;
    chk("pre_rst_err", 32'(bus16.err_count_o), 32'd1);
    v_r = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_locked",   32'(bus16.locked_o), 32'd0);
    chk("arst_word_err", 32'(bus16.word_err_o), 32'd0);
    chk("arst_zero",     32'(bus16.zero_detect_o), 32'd0);
    chk("arst_err",      32'(bus16.err_count_o), 32'd0);
    chk("arst_expected", 32'(bus16.expected_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply(1, seq[p], 0);
      p++;
      chk("arst_hunt_locked", 32'(bus16.locked_o), 32'd0);
    end
    apply(1, seq[p], 0);
    p++;
    chk("arst_relock", 32'(bus16.locked_o), 32'd1);
    chk("arst_relock_exp", 32'(bus16.expected_o), 32'(seq[p]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
